// File: rtl/rng_share_pkg.sv
// Shared definitions for the RNG engine sharing controller: FSM state
// encoding, config register addresses and the default seed.
package rng_share_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WARM = 2'd2
    } state_t;

    localparam logic [1:0]  CFG_ADR_SEED_HI  = 2'd1;
    localparam logic [1:0]  CFG_ADR_SEED_LO  = 2'd2;
    localparam logic [63:0] SEED_RST_DEFAULT = 64'h123456789abcdef0;

    // Round-robin pointer advance: the requester after the winner, wrapping.
    function automatic int unsigned next_index(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rng_share_ctrl_rr_pick.sv
// Combinational round-robin picker: scans the eligible vector starting at
// ptr and wrapping, returning the first hit as one-hot, as an index and as
// an "any" flag.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] j;

    // First eligible requester at or after ptr, modulo N.
    always_comb begin
        win = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int i = 0; i < N; i++) begin
            j = IW'((int'(ptr) + i) % N);
            if (!any && elig[j]) begin
                any    = 1'b1;
                idx    = j;
                win[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rng_share_ctrl.sv
// Arbiter/sequencer sharing one PCG step engine among NREQ requesters.
// Draws are granted round-robin, one per cycle; an atomic reseed (stage hi,
// stage lo + commit) loads the engine and discards WARMUP steps before
// draws resume. Reseed always takes priority over draws.
//
// Optional build macro RNG_SHARE_STATS_EN adds draw_count_o, a saturating
// count of acks that is cleared by a seed commit.
//
// state  | meaning
// S_IDLE | serving draws; leaves for S_LOAD when a commit is pending
// S_LOAD | one-cycle engine load from the staged seed
// S_WARM | discarding WARMUP engine steps after the load
module rng_share_ctrl
    import rng_share_pkg::*;
#(
    parameter int          NREQ     = 4,
    parameter int          WARMUP   = 2,
    parameter logic [63:0] SEED_RST = SEED_RST_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] ack_o,
    output logic [31:0]     rnd_o,
    input  logic            cfg_we_i,
    input  logic [1:0]      cfg_adr_i,
    input  logic [31:0]     cfg_dat_i,
    output logic            busy_o,
    input  logic [31:0]     eng_out_i,
    output logic            eng_step_o,
    output logic            eng_load_o,
    output logic [63:0]     eng_seed_o
`ifdef RNG_SHARE_STATS_EN
    ,
    output logic [31:0]     draw_count_o
`endif
);

    localparam int         IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0] WARM_INIT = 8'(WARMUP);

    state_t          state;
    state_t          state_nx;
    logic            pend;
    logic [63:0]     staging;
    logic [7:0]      warm_cnt;
    logic [IW-1:0]   ptr;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] win;
    logic [IW-1:0]   win_idx;
    logic            win_any;
    logic            grant;
    logic            step;
    logic            load;
    logic            wr_hi;
    logic            wr_lo;

    assign wr_hi = cfg_we_i && (cfg_adr_i == CFG_ADR_SEED_HI);
    assign wr_lo = cfg_we_i && (cfg_adr_i == CFG_ADR_SEED_LO);

    // A requester acked this cycle still has its level request up; mask it
    // so it cannot win twice on the same request.
    assign elig = req_i & ~ack_o;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .elig (elig),
        .ptr  (ptr),
        .win  (win),
        .idx  (win_idx),
        .any  (win_any)
    );

    // Next-state and engine control decode.
    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        step     = 1'b0;
        load     = 1'b0;
        case (state)
            S_IDLE: begin
                if (pend) begin
                    state_nx = S_LOAD;
                end else if (win_any) begin
                    grant = 1'b1;
                    step  = 1'b1;
                end
            end
            S_LOAD: begin
                load     = 1'b1;
                state_nx = (WARMUP == 0) ? S_IDLE : S_WARM;
            end
            S_WARM: begin
                step = 1'b1;
                if (warm_cnt <= 8'd1) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Engine strobes are held off for as long as reset is applied.
    assign eng_step_o = rst_n & step;
    assign eng_load_o = rst_n & load;
    assign eng_seed_o = staging;
    assign busy_o     = pend | (state != S_IDLE);

    // FSM state, grant pipeline and warm-up counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ptr      <= '0;
            ack_o    <= '0;
            rnd_o    <= '0;
            warm_cnt <= '0;
        end else begin
            state <= state_nx;
            ack_o <= grant ? win : '0;
            if (grant) begin
                // rnd_o carries the pre-step engine word seen in the grant cycle.
                rnd_o <= eng_out_i;
                ptr   <= IW'(next_index(int'(win_idx), NREQ));
            end
            if (state == S_LOAD) begin
                warm_cnt <= WARM_INIT;
            end else if (state == S_WARM && warm_cnt != 8'd0) begin
                warm_cnt <= warm_cnt - 8'd1;
            end
        end
    end

    // Seed staging and commit flag; a commit landing in the S_LOAD cycle
    // keeps pend set so a second reseed follows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            staging <= SEED_RST;
            pend    <= 1'b0;
        end else begin
            if (wr_hi) begin
                staging[63:32] <= cfg_dat_i;
            end
            if (wr_lo) begin
                staging[31:0] <= cfg_dat_i;
            end
            if (wr_lo) begin
                pend <= 1'b1;
            end else if (state == S_LOAD) begin
                pend <= 1'b0;
            end
        end
    end

`ifdef RNG_SHARE_STATS_EN
    logic [31:0] draw_cnt;

    // Saturating draw counter, counted when the ack is scheduled so it
    // updates together with ack_o.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            draw_cnt <= '0;
        end else if (wr_lo) begin
            draw_cnt <= '0;
        end else if (grant && draw_cnt != 32'hFFFF_FFFF) begin
            draw_cnt <= draw_cnt + 32'd1;
        end
    end

    assign draw_count_o = draw_cnt;
`endif

endmodule

// File: tb/tb_rng_share_ctrl.sv
// Directed bench for rng_share_ctrl (NREQ=4, WARMUP=2): table-driven draw
// arbitration vectors followed by hand-written reseed and reset sequences.
// Inputs change 1 time unit after posedge; outputs are checked at negedge.
module tb_rng_share_ctrl;
    import rng_share_pkg::*;

    localparam logic [63:0] SEED0 = 64'h123456789abcdef0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_i;
    logic [3:0]  ack_o;
    logic [31:0] rnd_o;
    logic        cfg_we_i;
    logic [1:0]  cfg_adr_i;
    logic [31:0] cfg_dat_i;
    logic        busy_o;
    logic [31:0] eng_out_i;
    logic        eng_step_o;
    logic        eng_load_o;
    logic [63:0] eng_seed_o;
`ifdef RNG_SHARE_STATS_EN
    logic [31:0] draw_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rng_share_ctrl #(
        .NREQ     (4),
        .WARMUP   (2),
        .SEED_RST (SEED0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .ack_o      (ack_o),
        .rnd_o      (rnd_o),
        .cfg_we_i   (cfg_we_i),
        .cfg_adr_i  (cfg_adr_i),
        .cfg_dat_i  (cfg_dat_i),
        .busy_o     (busy_o),
        .eng_out_i  (eng_out_i),
        .eng_step_o (eng_step_o),
        .eng_load_o (eng_load_o),
        .eng_seed_o (eng_seed_o)
`ifdef RNG_SHARE_STATS_EN
        ,
        .draw_count_o (draw_count)
`endif
    );

    typedef struct {
        logic [3:0]  req;
        logic [31:0] eng;
        logic        step;
        logic [3:0]  ack;
        logic [31:0] rnd;
    } vec_t;

    vec_t vt[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic start_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] req, input logic we, input logic [1:0] adr,
                         input logic [31:0] dat, input logic [31:0] eng);
        req_i     = req;
        cfg_we_i  = we;
        cfg_adr_i = adr;
        cfg_dat_i = dat;
        eng_out_i = eng;
    endtask

    task automatic ctl(input string tag, input logic step, input logic load,
                       input logic busy, input logic [3:0] ack);
        check({tag, ".step"}, 64'(eng_step_o), 64'(step));
        check({tag, ".load"}, 64'(eng_load_o), 64'(load));
        check({tag, ".busy"}, 64'(busy_o), 64'(busy));
        check({tag, ".ack"},  64'(ack_o), 64'(ack));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        // Arbitration vectors from reset (ptr=0). ack/rnd are the values
        // registered from the previous row's grant.
        vt[0]  = '{4'b0001, 32'hA000_0000, 1'b1, 4'b0000, 32'h0000_0000};
        vt[1]  = '{4'b0000, 32'hA000_0001, 1'b0, 4'b0001, 32'hA000_0000};
        vt[2]  = '{4'b1111, 32'hB000_0000, 1'b1, 4'b0000, 32'hA000_0000};
        vt[3]  = '{4'b1111, 32'hB000_0001, 1'b1, 4'b0010, 32'hB000_0000};
        vt[4]  = '{4'b1111, 32'hB000_0002, 1'b1, 4'b0100, 32'hB000_0001};
        vt[5]  = '{4'b1111, 32'hB000_0003, 1'b1, 4'b1000, 32'hB000_0002};
        vt[6]  = '{4'b1111, 32'hB000_0004, 1'b1, 4'b0001, 32'hB000_0003};
        vt[7]  = '{4'b0000, 32'hC000_0000, 1'b0, 4'b0010, 32'hB000_0004};
        vt[8]  = '{4'b0101, 32'hC000_0001, 1'b1, 4'b0000, 32'hB000_0004};
        vt[9]  = '{4'b0101, 32'hC000_0002, 1'b1, 4'b0100, 32'hC000_0001};
        vt[10] = '{4'b0101, 32'hC000_0003, 1'b1, 4'b0001, 32'hC000_0002};
        vt[11] = '{4'b0000, 32'hC000_0004, 1'b0, 4'b0100, 32'hC000_0003};
        vt[12] = '{4'b1000, 32'hC000_0005, 1'b1, 4'b0000, 32'hC000_0003};
        vt[13] = '{4'b1000, 32'hC000_0006, 1'b0, 4'b1000, 32'hC000_0005};
        vt[14] = '{4'b1000, 32'hC000_0007, 1'b1, 4'b0000, 32'hC000_0005};
        vt[15] = '{4'b0000, 32'hC000_0008, 1'b0, 4'b1000, 32'hC000_0007};

        // Reset: strobes must stay low even with a request present.
        rst_n = 1'b0;
        drive(4'b1111, 1'b0, 2'd0, 32'h0, 32'h0);
        start_cyc();
        mid();
        check("rst.ack", 64'(ack_o), 64'h0);
        check("rst.rnd", 64'(rnd_o), 64'h0);
        check("rst.busy", 64'(busy_o), 64'h0);
        check("rst.step", 64'(eng_step_o), 64'h0);
        check("rst.seed", eng_seed_o, SEED0);
`ifdef RNG_SHARE_STATS_EN
        check("rst.count", 64'(draw_count), 64'h0);
`endif

        // Table-driven arbitration.
        for (int i = 0; i < 16; i++) begin
            start_cyc();
            if (i == 0) rst_n = 1'b1;
            drive(vt[i].req, 1'b0, 2'd0, 32'h0, vt[i].eng);
            mid();
            check($sformatf("vec%0d.step", i), 64'(eng_step_o), 64'(vt[i].step));
            check($sformatf("vec%0d.ack", i), 64'(ack_o), 64'(vt[i].ack));
            check($sformatf("vec%0d.rnd", i), 64'(rnd_o), 64'(vt[i].rnd));
            check($sformatf("vec%0d.busy", i), 64'(busy_o), 64'h0);
            check($sformatf("vec%0d.load", i), 64'(eng_load_o), 64'h0);
        end
        // ptr is now 0.

        // Reseed: stage hi, commit lo, then load + 2 warm-up steps.
        start_cyc(); drive(4'b0000, 1'b1, CFG_ADR_SEED_HI, 32'hDEADBEEF, 32'h5100_0000);
        mid();       ctl("rs.hi", 1'b0, 1'b0, 1'b0, 4'b0000);
        start_cyc(); drive(4'b0000, 1'b1, CFG_ADR_SEED_LO, 32'h01234567, 32'h5100_0001);
        mid();       ctl("rs.lo", 1'b0, 1'b0, 1'b0, 4'b0000);
        start_cyc(); drive(4'b0010, 1'b0, 2'd0, 32'h0, 32'h5100_0002);
        mid();       ctl("rs.pend", 1'b0, 1'b0, 1'b1, 4'b0000);
        start_cyc(); drive(4'b0010, 1'b0, 2'd0, 32'h0, 32'h5100_0003);
        mid();       ctl("rs.load", 1'b0, 1'b1, 1'b1, 4'b0000);
        check("rs.seed", eng_seed_o, 64'hDEADBEEF01234567);
        start_cyc(); drive(4'b0010, 1'b0, 2'd0, 32'h0, 32'h5100_0004);
        mid();       ctl("rs.warm0", 1'b1, 1'b0, 1'b1, 4'b0000);
        start_cyc(); drive(4'b0010, 1'b0, 2'd0, 32'h0, 32'h5100_0005);
        mid();       ctl("rs.warm1", 1'b1, 1'b0, 1'b1, 4'b0000);
        start_cyc(); drive(4'b0010, 1'b0, 2'd0, 32'h0, 32'hA5A5_0003);
        mid();       ctl("rs.idle", 1'b1, 1'b0, 1'b0, 4'b0000);
        start_cyc(); drive(4'b0000, 1'b0, 2'd0, 32'h0, 32'h5100_0007);
        mid();       ctl("rs.ack", 1'b0, 1'b0, 1'b0, 4'b0010);
        check("rs.rnd", 64'(rnd_o), 64'hA5A5_0003);
        // ptr is now 2.

        // Commit during S_WARM: second load follows the return to S_IDLE
        // with no grants in between, even though all requests are held.
        start_cyc(); drive(4'b0000, 1'b1, CFG_ADR_SEED_LO, 32'h0BADF00D, 32'h6100_0000);
        mid();       ctl("rr.lo", 1'b0, 1'b0, 1'b0, 4'b0000);
        start_cyc(); drive(4'b1111, 1'b0, 2'd0, 32'h0, 32'h6100_0001);
        mid();       ctl("rr.pend", 1'b0, 1'b0, 1'b1, 4'b0000);
        start_cyc(); drive(4'b1111, 1'b0, 2'd0, 32'h0, 32'h6100_0002);
        mid();       ctl("rr.load1", 1'b0, 1'b1, 1'b1, 4'b0000);
        check("rr.seed1", eng_seed_o, 64'hDEADBEEF0BADF00D);
        start_cyc(); drive(4'b1111, 1'b1, CFG_ADR_SEED_LO, 32'hCAFEF00D, 32'h6100_0003);
        mid();       ctl("rr.warm0", 1'b1, 1'b0, 1'b1, 4'b0000);
        start_cyc(); drive(4'b1111, 1'b0, 2'd0, 32'h0, 32'h6100_0004);
        mid();       ctl("rr.warm1", 1'b1, 1'b0, 1'b1, 4'b0000);
        start_cyc(); drive(4'b1111, 1'b0, 2'd0, 32'h0, 32'h6100_0005);
        mid();       ctl("rr.idle", 1'b0, 1'b0, 1'b1, 4'b0000);
        start_cyc(); drive(4'b1111, 1'b0, 2'd0, 32'h0, 32'h6100_0006);
        mid();       ctl("rr.load2", 1'b0, 1'b1, 1'b1, 4'b0000);
        check("rr.seed2", eng_seed_o, 64'hDEADBEEFCAFEF00D);
        start_cyc(); drive(4'b1111, 1'b0, 2'd0, 32'h0, 32'h6100_0007);
        mid();       ctl("rr.warm2", 1'b1, 1'b0, 1'b1, 4'b0000);
        start_cyc(); drive(4'b1111, 1'b0, 2'd0, 32'h0, 32'h6100_0008);
        mid();       ctl("rr.warm3", 1'b1, 1'b0, 1'b1, 4'b0000);
        start_cyc(); drive(4'b1111, 1'b0, 2'd0, 32'h0, 32'h6100_0009);
        mid();       ctl("rr.grant", 1'b1, 1'b0, 1'b0, 4'b0000);
        start_cyc(); drive(4'b0000, 1'b0, 2'd0, 32'h0, 32'h6100_000A);
        mid();       ctl("rr.ack", 1'b0, 1'b0, 1'b0, 4'b0100);
        check("rr.rnd", 64'(rnd_o), 64'h6100_0009);
        // ptr is now 3.

        // Reset with a commit pending and a grant about to be made.
        start_cyc(); drive(4'b0000, 1'b1, CFG_ADR_SEED_LO, 32'h7777_7777, 32'h7100_0000);
        mid();
        start_cyc(); rst_n = 1'b0; drive(4'b0001, 1'b0, 2'd0, 32'h0, 32'h7100_0001);
        mid();       ctl("xr.inrst", 1'b0, 1'b0, 1'b1, 4'b0000);
        start_cyc(); rst_n = 1'b1; drive(4'b1111, 1'b0, 2'd0, 32'h0, 32'h7100_0002);
        mid();       ctl("xr.after", 1'b1, 1'b0, 1'b0, 4'b0000);
        check("xr.rnd", 64'(rnd_o), 64'h0);
        check("xr.seed", eng_seed_o, SEED0);
        for (int k = 0; k < 4; k++) begin
            start_cyc(); drive(4'b1111, 1'b0, 2'd0, 32'h0, 32'h7100_0003 + 32'(k));
            mid();
            check($sformatf("xr.rr%0d", k), 64'(ack_o), 64'(4'b0001 << k));
        end
        check("xr.rnd2", 64'(rnd_o), 64'h7100_0005);
        start_cyc(); drive(4'b0000, 1'b0, 2'd0, 32'h0, 32'h7100_0010);
        mid();       ctl("xr.ackw", 1'b0, 1'b0, 1'b0, 4'b0001);

`ifdef RNG_SHARE_STATS_EN
        // Five grants since reset (ptr now 1).
        check("st.count5", 64'(draw_count), 64'd5);
        start_cyc(); drive(4'b0000, 1'b0, 2'd0, 32'h0, 32'h0);
        force dut.draw_cnt = 32'hFFFF_FFFF;
        mid();
        release dut.draw_cnt;
        start_cyc(); drive(4'b0001, 1'b0, 2'd0, 32'h0, 32'h0);
        mid();       check("st.satstep", 64'(eng_step_o), 64'h1);
        start_cyc(); drive(4'b0000, 1'b0, 2'd0, 32'h0, 32'h0);
        mid();       check("st.sat", 64'(draw_count), 64'hFFFF_FFFF);
        start_cyc(); drive(4'b0000, 1'b1, CFG_ADR_SEED_LO, 32'h1, 32'h0);
        mid();
        start_cyc(); drive(4'b0000, 1'b0, 2'd0, 32'h0, 32'h0);
        mid();       check("st.clear", 64'(draw_count), 64'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
